// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: forwarding selects, stall/flush, memory watchdog.
// Optional HAZARD_PERF_EN adds 32-bit stall/flush cycle counters.
module hazard_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int TMO_WIDTH   = 8,
    parameter int MEM_TIMEOUT = 200
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    input  logic [ADDR_WIDTH-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  id_mem_en,
    input  logic                  ex_pc_src,
    input  logic                  dmem_ready,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_fd,
    output logic                  stall_all,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  mem_err,
    output logic [31:0]           perf_stall,
    output logic [31:0]           perf_flush
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(MEM_TIMEOUT - 1);
    localparam logic [TMO_WIDTH-1:0] TMO_MAX  = '1;

    logic [ADDR_WIDTH-1:0] e_rs1_q, e_rs1_d;
    logic [ADDR_WIDTH-1:0] e_rs2_q, e_rs2_d;
    logic [ADDR_WIDTH-1:0] e_rd_q, e_rd_d;
    logic                  e_rw_q, e_rw_d;
    logic                  e_load_q, e_load_d;
    logic                  e_mem_q, e_mem_d;
    logic [ADDR_WIDTH-1:0] m_rd_q, m_rd_d;
    logic                  m_rw_q, m_rw_d;
    logic                  m_mem_q, m_mem_d;
    logic [ADDR_WIDTH-1:0] w_rd_q, w_rd_d;
    logic                  w_rw_q, w_rw_d;

    state_t                state_q, state_d;
    logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;
    logic                  mem_err_q, mem_err_d;

    logic                  load_use;
    logic                  m_fwd_ok;
    logic                  w_fwd_ok;

    always_comb begin
        m_fwd_ok = m_rw_q && (m_rd_q != '0);
        w_fwd_ok = w_rw_q && (w_rd_q != '0);

        fwd_a_sel = 2'd0;
        if (m_fwd_ok && (m_rd_q == e_rs1_q))
            fwd_a_sel = 2'd2;
        else if (w_fwd_ok && (w_rd_q == e_rs1_q))
            fwd_a_sel = 2'd1;

        fwd_b_sel = 2'd0;
        if (m_fwd_ok && (m_rd_q == e_rs2_q))
            fwd_b_sel = 2'd2;
        else if (w_fwd_ok && (w_rd_q == e_rs2_q))
            fwd_b_sel = 2'd1;
    end

    // A pending memory access overrides everything; branch squashes the load-use stall.
    always_comb begin
        load_use  = e_load_q && (e_rd_q != '0) &&
                    ((e_rd_q == id_rs1) || (e_rd_q == id_rs2));
        stall_all = m_mem_q && !dmem_ready;
        stall_fd  = stall_all || (load_use && !ex_pc_src);
        flush_d   = !stall_all && ex_pc_src;
        flush_e   = !stall_all && (ex_pc_src || load_use);
    end

    always_comb begin
        e_rs1_d  = e_rs1_q;
        e_rs2_d  = e_rs2_q;
        e_rd_d   = e_rd_q;
        e_rw_d   = e_rw_q;
        e_load_d = e_load_q;
        e_mem_d  = e_mem_q;
        m_rd_d   = m_rd_q;
        m_rw_d   = m_rw_q;
        m_mem_d  = m_mem_q;
        w_rd_d   = w_rd_q;
        w_rw_d   = w_rw_q;
        if (!stall_all) begin
            if (flush_e || stall_fd) begin
                e_rs1_d  = '0;
                e_rs2_d  = '0;
                e_rd_d   = '0;
                e_rw_d   = 1'b0;
                e_load_d = 1'b0;
                e_mem_d  = 1'b0;
            end else begin
                e_rs1_d  = id_rs1;
                e_rs2_d  = id_rs2;
                e_rd_d   = id_rd;
                e_rw_d   = id_reg_write;
                e_load_d = id_is_load;
                e_mem_d  = id_mem_en;
            end
            m_rd_d  = e_rd_q;
            m_rw_d  = e_rw_q;
            m_mem_d = e_mem_q;
            w_rd_d  = m_rd_q;
            w_rw_d  = m_rw_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        mem_err_d = mem_err_q;
        unique case (state_q)
            RUN: begin
                if (stall_all)
                    state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                end else begin
                    tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
                    if (tmo_d == TMO_LAST)
                        mem_err_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_rs1_q   <= '0;
            e_rs2_q   <= '0;
            e_rd_q    <= '0;
            e_rw_q    <= 1'b0;
            e_load_q  <= 1'b0;
            e_mem_q   <= 1'b0;
            m_rd_q    <= '0;
            m_rw_q    <= 1'b0;
            m_mem_q   <= 1'b0;
            w_rd_q    <= '0;
            w_rw_q    <= 1'b0;
            state_q   <= RUN;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            e_rs1_q   <= e_rs1_d;
            e_rs2_q   <= e_rs2_d;
            e_rd_q    <= e_rd_d;
            e_rw_q    <= e_rw_d;
            e_load_q  <= e_load_d;
            e_mem_q   <= e_mem_d;
            m_rd_q    <= m_rd_d;
            m_rw_q    <= m_rw_d;
            m_mem_q   <= m_mem_d;
            w_rd_q    <= w_rd_d;
            w_rw_q    <= w_rw_d;
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, stall_fd};
        perf_flush_d = perf_flush_q + {31'd0, flush_e};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch, memory wait and watchdog.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_is_load, id_mem_en;
    logic        ex_pc_src, dmem_ready;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall_fd, stall_all, flush_d, flush_e, mem_err;
    logic [31:0] perf_stall, perf_flush;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(
        .ADDR_WIDTH (5),
        .TMO_WIDTH  (8),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_reg_write(id_reg_write),
        .id_is_load  (id_is_load),
        .id_mem_en   (id_mem_en),
        .ex_pc_src   (ex_pc_src),
        .dmem_ready  (dmem_ready),
        .fwd_a_sel   (fwd_a_sel),
        .fwd_b_sel   (fwd_b_sel),
        .stall_fd    (stall_fd),
        .stall_all   (stall_all),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .mem_err     (mem_err),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic ld, input logic mem);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_reg_write = rw;
        id_is_load   = ld;
        id_mem_en    = mem;
        #1;
    endtask

    task automatic nops(input int n);
        set_id(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_ctl(input string tag, input logic sfd, input logic sall,
                           input logic fd, input logic fe);
        chk({tag, "_stall_fd"}, {31'd0, stall_fd}, {31'd0, sfd});
        chk({tag, "_stall_all"}, {31'd0, stall_all}, {31'd0, sall});
        chk({tag, "_flush_d"}, {31'd0, flush_d}, {31'd0, fd});
        chk({tag, "_flush_e"}, {31'd0, flush_e}, {31'd0, fe});
    endtask

    task automatic chk_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        chk({tag, "_fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, a});
        chk({tag, "_fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, b});
    endtask

    initial begin
        rst        = 1'b1;
        ex_pc_src  = 1'b0;
        dmem_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_fwd("rst", 2'd0, 2'd0);
        chk_ctl("rst", 0, 0, 0, 0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
        rst = 1'b0;
        #1;
        chk_fwd("post_rst", 2'd0, 2'd0);
        chk_ctl("post_rst", 0, 0, 0, 0);

        // forwarding: A add x5; B add x5,x5,x0; C add x7,x5,x5; D add x9,x3,x5
        set_id(1, 2, 5, 1, 0, 0);
        tick();
        set_id(5, 0, 5, 1, 0, 0);
        tick();
        chk_fwd("fwd_mem", 2'd2, 2'd0);
        set_id(5, 5, 7, 1, 0, 0);
        tick();
        chk_fwd("fwd_prio", 2'd2, 2'd2);
        set_id(3, 5, 9, 1, 0, 0);
        tick();
        chk_fwd("fwd_wb", 2'd0, 2'd1);
        chk_ctl("fwd_ctl", 0, 0, 0, 0);
        nops(3);

        // load-use: lw x6 ; add x7,x6,x6
        set_id(1, 0, 6, 1, 1, 1);
        tick();
        set_id(6, 6, 7, 1, 0, 0);
        chk_ctl("lu_hit", 1, 0, 0, 1);
        tick();
        chk_ctl("lu_once", 0, 0, 0, 0);
        chk_fwd("lu_bubble", 2'd0, 2'd0);
        tick();
        chk_fwd("lu_wb", 2'd1, 2'd1);
        nops(3);

        // x0 is never forwarded, load into x0 never stalls
        set_id(1, 2, 0, 1, 0, 0);
        tick();
        set_id(0, 0, 1, 1, 0, 0);
        tick();
        chk_fwd("x0_fwd", 2'd0, 2'd0);
        set_id(1, 0, 0, 1, 1, 1);
        tick();
        set_id(0, 0, 3, 1, 0, 0);
        chk_ctl("x0_load", 0, 0, 0, 0);
        nops(3);

        // branch during pending load-use
        set_id(1, 0, 6, 1, 1, 1);
        tick();
        set_id(6, 0, 8, 1, 0, 0);
        ex_pc_src = 1'b1;
        #1;
        chk_ctl("br_lu", 0, 0, 1, 1);
        tick();
        ex_pc_src = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        chk_ctl("br_after", 0, 0, 0, 0);
        nops(3);

        // memory wait: add x4 ; sw ; add x9,x4,x0 ; dmem_ready low 3 cycles
        set_id(1, 2, 4, 1, 0, 0);
        tick();
        set_id(2, 3, 0, 0, 0, 1);
        tick();
        set_id(4, 0, 9, 1, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        chk_fwd("mw_pre", 2'd1, 2'd0);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_pc_src = (i == 1);
            #1;
            chk_ctl($sformatf("mw_c%0d", i), 1, 1, 0, 0);
            chk_fwd($sformatf("mw_c%0d", i), 2'd1, 2'd0);
            tick();
        end
        ex_pc_src  = 1'b0;
        dmem_ready = 1'b1;
        #1;
        chk_ctl("mw_done", 0, 0, 0, 0);
        chk_fwd("mw_frozen", 2'd1, 2'd0);
        tick();
        chk_fwd("mw_adv", 2'd0, 2'd0);
        chk("mw_no_err", {31'd0, mem_err}, 32'd0);
        nops(3);

        // watchdog
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_id(2, 3, 0, 0, 0, 1);
        tick();
        set_id(0, 0, 0, 0, 0, 0);
        tick();
        dmem_ready = 1'b0;
        #1;
        chk("wd_stall", {31'd0, stall_all}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("wd_err_c%0d", i), {31'd0, mem_err}, 32'd0);
        end
        tick();
        chk("wd_err_set", {31'd0, mem_err}, 32'd1);
`ifdef HAZARD_PERF_EN
        chk("wd_perf_stall", perf_stall, 32'd4);
        chk("wd_perf_flush", perf_flush, 32'd0);
`else
        chk("wd_perf_off", perf_stall, 32'd0);
`endif
        tick();
        chk("wd_err_sticky", {31'd0, mem_err}, 32'd1);
        chk("wd_still_stall", {31'd0, stall_all}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("wd_rst_err", {31'd0, mem_err}, 32'd0);
        chk("wd_rst_stall", {31'd0, stall_all}, 32'd0);
        chk("wd_rst_perf", perf_stall, 32'd0);
        rst = 1'b0;
        dmem_ready = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
